// File: rtl/mips_perf_pkg.sv
// Shared definitions for the MIPS performance-counter unit and its AXI-Lite slave.
package mips_perf_pkg;

    // Run/halt FSM encoding
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    // Counter indices
    localparam int unsigned NumCnt    = 8;
    localparam int unsigned CntCyc    = 0;
    localparam int unsigned CntInst   = 1;
    localparam int unsigned CntBr     = 2;
    localparam int unsigned CntLd     = 3;
    localparam int unsigned CntSt     = 4;
    localparam int unsigned CntUser1  = 5;
    localparam int unsigned CntUser2  = 6;
    localparam int unsigned CntUser3  = 7;

    // AXI word offsets (0x1..0x8) as seen by the slave
    localparam logic [3:0] OffCyc   = 4'h1;
    localparam logic [3:0] OffInst  = 4'h2;
    localparam logic [3:0] OffBr    = 4'h3;
    localparam logic [3:0] OffLd    = 4'h4;
    localparam logic [3:0] OffSt    = 4'h5;
    localparam logic [3:0] OffUser1 = 4'h6;
    localparam logic [3:0] OffUser2 = 4'h7;
    localparam logic [3:0] OffUser3 = 4'h8;

    // Map a counter index to its AXI word offset
    function automatic logic [3:0] cnt_offset(input int unsigned idx);
        return 4'(idx + 1);
    endfunction

endpackage

// File: rtl/mips_perf_ctr.sv
// Single event counter: synchronous clear, increment, wrap or saturate.
// MIPS_PERF_SATURATE_EN selects saturation and adds a sticky sat_o flag.
module mips_perf_ctr #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 clr_i,
`ifdef MIPS_PERF_SATURATE_EN
    output logic                 sat_o,
`endif
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

`ifdef MIPS_PERF_SATURATE_EN
    logic sat_q, sat_d;

    // Next count: clear wins, then saturating increment with sticky flag
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Sticky saturation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    // Next count: clear wins, otherwise a silently wrapping increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`endif

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mips_perf_cnt.sv
// MIPS performance-counter unit: run/halt FSM, eight event counters and a
// freezable snapshot register feeding the AXI-Lite slave.
// MIPS_PERF_SATURATE_EN: counters saturate and sat_flags_o is present.
module mips_perf_cnt
    import mips_perf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned USER_NUM  = 3   // user1..user3 mapping assumes exactly 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                halt_i,
    input  logic                freeze_i,
    input  logic                clr_i,
    input  logic                ev_retire_i,
    input  logic                ev_branch_i,
    input  logic                ev_load_i,
    input  logic                ev_store_i,
    input  logic [USER_NUM-1:0] ev_user_i,
    output logic [31:0]         cycle_cnt_o,
    output logic [31:0]         inst_cnt_o,
    output logic [31:0]         br_cnt_o,
    output logic [31:0]         ld_cnt_o,
    output logic [31:0]         st_cnt_o,
    output logic [31:0]         user1_cnt_o,
    output logic [31:0]         user2_cnt_o,
    output logic [31:0]         user3_cnt_o,
`ifdef MIPS_PERF_SATURATE_EN
    output logic [7:0]          sat_flags_o,
`endif
    output logic                running_o
);

    logic [1:0]           state_q, state_d;
    logic                 counting;
    logic [NumCnt-1:0]    inc;
    logic [CNT_WIDTH-1:0] live [NumCnt];
    logic [31:0]          snap_q [NumCnt];
    logic [31:0]          snap_d [NumCnt];

    // Run/halt next state; clr overrides start/halt
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:   if (start_i) state_d = StRun;
                StRun:    if (halt_i) state_d = StHalted;
                StHalted: if (start_i && !halt_i) state_d = StRun;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign counting  = (state_q == StRun);
    assign running_o = counting;

    // Per-counter increment enables; class events only count on retirement
    always_comb begin
        inc           = '0;
        inc[CntCyc]   = counting;
        inc[CntInst]  = counting && ev_retire_i;
        inc[CntBr]    = counting && ev_retire_i && ev_branch_i;
        inc[CntLd]    = counting && ev_retire_i && ev_load_i;
        inc[CntSt]    = counting && ev_retire_i && ev_store_i;
        inc[CntUser1] = counting && ev_user_i[0];
        inc[CntUser2] = counting && ev_user_i[1];
        inc[CntUser3] = counting && ev_user_i[2];
    end

`ifdef MIPS_PERF_SATURATE_EN
    logic [NumCnt-1:0] sat;
    assign sat_flags_o = sat;
`endif

    for (genvar i = 0; i < NumCnt; i++) begin : g_ctr
        mips_perf_ctr #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .inc_i (inc[i]),
            .clr_i (clr_i),
`ifdef MIPS_PERF_SATURATE_EN
            .sat_o (sat[i]),
`endif
            .cnt_o (live[i])
        );
    end

    // Snapshot follows the live counters one cycle late unless frozen
    always_comb begin
        for (int i = 0; i < NumCnt; i++) begin
            snap_d[i] = freeze_i ? snap_q[i] : 32'(live[i]);
        end
    end

    // Snapshot register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumCnt; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumCnt; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign cycle_cnt_o = snap_q[CntCyc];
    assign inst_cnt_o  = snap_q[CntInst];
    assign br_cnt_o    = snap_q[CntBr];
    assign ld_cnt_o    = snap_q[CntLd];
    assign st_cnt_o    = snap_q[CntSt];
    assign user1_cnt_o = snap_q[CntUser1];
    assign user2_cnt_o = snap_q[CntUser2];
    assign user3_cnt_o = snap_q[CntUser3];

endmodule

// File: tb/tb_mips_perf_cnt.sv
// Self-checking bench for mips_perf_cnt (CNT_WIDTH=16 so wrap is reachable).
module tb_mips_perf_cnt;

    localparam int unsigned CW   = 16;
    localparam int unsigned MAXV = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, halt_i, freeze_i, clr_i;
    logic        ev_retire_i, ev_branch_i, ev_load_i, ev_store_i;
    logic [2:0]  ev_user_i;
    logic [31:0] obs [8];
    logic        running_o;
`ifdef MIPS_PERF_SATURATE_EN
    logic [7:0]  sat_flags_o;
`endif

    always #5 clk = ~clk;

    mips_perf_cnt #(
        .CNT_WIDTH (CW),
        .USER_NUM  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .halt_i      (halt_i),
        .freeze_i    (freeze_i),
        .clr_i       (clr_i),
        .ev_retire_i (ev_retire_i),
        .ev_branch_i (ev_branch_i),
        .ev_load_i   (ev_load_i),
        .ev_store_i  (ev_store_i),
        .ev_user_i   (ev_user_i),
        .cycle_cnt_o (obs[0]),
        .inst_cnt_o  (obs[1]),
        .br_cnt_o    (obs[2]),
        .ld_cnt_o    (obs[3]),
        .st_cnt_o    (obs[4]),
        .user1_cnt_o (obs[5]),
        .user2_cnt_o (obs[6]),
        .user3_cnt_o (obs[7]),
`ifdef MIPS_PERF_SATURATE_EN
        .sat_flags_o (sat_flags_o),
`endif
        .running_o   (running_o)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;
    string names [8] = '{"cycle", "inst", "br", "ld", "st", "user1", "user2", "user3"};

    // Reference model: plain event counts, the visible copy, and a mode word
    // (0 = idle, 1 = running, 2 = halted).
    int unsigned m_live [8];
    int unsigned m_snap [8];
    int          m_mode;
    logic [7:0]  m_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_live[i] = 0;
            m_snap[i] = 0;
        end
        m_mode = 0;
        m_sat  = '0;
    endtask

    task automatic bump(input int idx);
`ifdef MIPS_PERF_SATURATE_EN
        if (m_live[idx] == MAXV) m_sat[idx] = 1'b1;
        else m_live[idx] = m_live[idx] + 1;
`else
        m_live[idx] = (m_live[idx] + 1) % (MAXV + 1);
`endif
    endtask

    // What one clock edge does to the counts, from the inputs present at it
    task automatic model_edge();
        if (!freeze_i) begin
            for (int i = 0; i < 8; i++) m_snap[i] = m_live[i];
        end
        if (clr_i) begin
            for (int i = 0; i < 8; i++) m_live[i] = 0;
            m_sat  = '0;
            m_mode = 0;
        end else begin
            if (m_mode == 1) begin
                bump(0);
                if (ev_retire_i) begin
                    bump(1);
                    if (ev_branch_i) bump(2);
                    if (ev_load_i)   bump(3);
                    if (ev_store_i)  bump(4);
                end
                for (int k = 0; k < 3; k++) if (ev_user_i[k]) bump(5 + k);
            end
            if (m_mode == 0 && start_i) m_mode = 1;
            else if (m_mode == 1 && halt_i) m_mode = 2;
            else if (m_mode == 2 && start_i && !halt_i) m_mode = 1;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 8; i++) check(names[i], obs[i], m_snap[i]);
        check("running", 32'(running_o), 32'(m_mode == 1));
`ifdef MIPS_PERF_SATURATE_EN
        check("sat_flags", 32'(sat_flags_o), 32'(m_sat));
`endif
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample 1ns later
    task automatic cycle(input bit s, input bit h, input bit f, input bit c,
                         input bit r, input bit b, input bit l, input bit w,
                         input logic [2:0] u);
        start_i = s; halt_i = h; freeze_i = f; clr_i = c;
        ev_retire_i = r; ev_branch_i = b; ev_load_i = l; ev_store_i = w; ev_user_i = u;
        @(posedge clk);
        model_edge();
        #1;
        if (chk_en) compare_all();
        @(negedge clk);
    endtask

    initial begin
        bit f_lvl;
        start_i = 0; halt_i = 0; freeze_i = 0; clr_i = 0;
        ev_retire_i = 0; ev_branch_i = 0; ev_load_i = 0; ev_store_i = 0; ev_user_i = '0;
        model_reset();
        rst = 1'b1;
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // 10 retiring cycles, 3 of them loads
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, (i < 3), 0, 3'b000);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        check("t1_cycle", obs[0], 10);
        check("t1_inst", obs[1], 10);
        check("t1_ld", obs[3], 3);
        check("t1_st", obs[4], 0);
        check("t1_running", 32'(running_o), 1);

        // Unqualified branch strobes ignored; user events counted independently
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0, 3'b000);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b101);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        check("t2_br", obs[2], 0);
        check("t2_user1", obs[5], 4);
        check("t2_user2", obs[6], 0);
        check("t2_user3", obs[7], 4);

        // Halt after 20 running cycles, hold, then resume
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 3'b000);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        for (int i = 0; i < 51; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
        check("t3_halted_cycle", obs[0], 21);
        check("t3_halted_running", 32'(running_o), 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 0, 1, 3'b010);

        // Freeze at cycle count 100 for 30 cycles
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 3'b000);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 101; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        check("t4_pre_freeze", obs[0], 100);
        for (int i = 0; i < 30; i++) cycle(0, 0, 1, 0, 0, 0, 0, 0, 3'b000);
        check("t4_frozen", obs[0], 100);
        cycle(0, 0, 1, 1, 0, 0, 0, 0, 3'b000);
        check("t4_clr_frozen", obs[0], 100);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        check("t4_after_clr", obs[0], 0);

        // Wrap (or saturation) of the 16-bit cycle counter
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        chk_en = 1'b0;
        for (int i = 0; i < 65535; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        chk_en = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        check("t5_max", obs[0], MAXV);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
`ifdef MIPS_PERF_SATURATE_EN
        check("t5_sat", obs[0], MAXV);
        check("t5_sat_flag0", 32'(sat_flags_o[0]), 1);
`else
        check("t5_wrap", obs[0], 0);
`endif

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1, 0, 0, 3'b111);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_rst_cycle", obs[0], 0);
        check("t6_rst_inst", obs[1], 0);
        check("t6_rst_running", 32'(running_o), 0);
        compare_all();
        #1;
        rst = 1'b0;

        // clr together with start
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        cycle(1, 0, 0, 1, 1, 0, 0, 0, 3'b000);
        check("t6_clr_start_running", 32'(running_o), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        check("t6_clr_start_cycle", obs[0], 0);

        // Random traffic against the model
        f_lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) f_lvl = ~f_lvl;
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), f_lvl,
                  ($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
